// File: rtl/axis_rr_mux_pkg.sv
// Shared types and constants for the packet round-robin stream mux.
package axis_rr_mux_pkg;

    localparam int RR_MUX_MAX_IN = 16;
    localparam int AXI_DATA_BITS = 64;
    localparam int PID_BITS      = 4;

    typedef enum logic {
        RR_IDLE   = 1'b0,
        RR_LOCKED = 1'b1
    } rr_state_t;

endpackage

// File: rtl/axis_rr_mux_skid_reg.sv
// axis_skid_reg: generic 2-entry AXI-Stream register slice (tdata/tkeep/tlast/tid).
// Both the output and the upstream tready come straight from flops.
module axis_skid_reg
    import axis_rr_mux_pkg::*;
#(
    parameter int  DATA_BITS = AXI_DATA_BITS,
    parameter int  ID_BITS   = PID_BITS,
    localparam int KEEP_BITS = DATA_BITS / 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_s_tdata,
    input  logic [KEEP_BITS-1:0] i_s_tkeep,
    input  logic                 i_s_tlast,
    input  logic [ID_BITS-1:0]   i_s_tid,
    input  logic                 i_s_tvalid,
    output logic                 o_s_tready,
    output logic [DATA_BITS-1:0] o_m_tdata,
    output logic [KEEP_BITS-1:0] o_m_tkeep,
    output logic                 o_m_tlast,
    output logic [ID_BITS-1:0]   o_m_tid,
    output logic                 o_m_tvalid,
    input  logic                 i_m_tready
);

    localparam int P_BITS = DATA_BITS + KEEP_BITS + 1 + ID_BITS;

    logic [P_BITS-1:0] w_in;
    logic [P_BITS-1:0] r_main;
    logic [P_BITS-1:0] r_skid;
    logic              r_main_valid;
    logic              r_skid_valid;

    assign w_in       = {i_s_tdata, i_s_tkeep, i_s_tlast, i_s_tid};
    assign o_s_tready = ~r_skid_valid;
    assign {o_m_tdata, o_m_tkeep, o_m_tlast, o_m_tid} = r_main;
    assign o_m_tvalid = r_main_valid;

    // Main register refills from the skid entry first; the skid catches one beat while the output stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || i_m_tready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                if (i_s_tvalid) begin
                    r_main <= w_in;
                end
                r_main_valid <= i_s_tvalid;
            end
        end else if (i_s_tvalid && !r_skid_valid) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_rr_mux.sv
// axis_rr_mux: packet-level round-robin scheduler sharing one stream master among N_IN
// requesters. The grant is held until a tlast handshake; tid carries the source index.
// Define AXIS_RR_MUX_OUT_REG_EN to insert an axis_skid_reg slice on the output.
//
// state     | meaning
// RR_IDLE   | no grant held, outputs quiet
// RR_LOCKED | r_g owns the output until its tlast handshake
module axis_rr_mux
    import axis_rr_mux_pkg::*;
#(
    parameter int  N_IN      = 4,
    parameter int  DATA_BITS = AXI_DATA_BITS,
    parameter int  ID_BITS   = PID_BITS,
    localparam int KEEP_BITS = DATA_BITS / 8,
    localparam int SRC_BITS  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                            i_aclk,
    input  logic                            i_areset,
    input  logic [N_IN-1:0][DATA_BITS-1:0]  i_s_tdata,
    input  logic [N_IN-1:0][KEEP_BITS-1:0]  i_s_tkeep,
    input  logic [N_IN-1:0]                 i_s_tlast,
    input  logic [N_IN-1:0]                 i_s_tvalid,
    output logic [N_IN-1:0]                 o_s_tready,
    output logic [DATA_BITS-1:0]            o_m_tdata,
    output logic [KEEP_BITS-1:0]            o_m_tkeep,
    output logic                            o_m_tlast,
    output logic [ID_BITS-1:0]              o_m_tid,
    output logic                            o_m_tvalid,
    input  logic                            i_m_tready,
    output logic                            o_busy,
    output logic [SRC_BITS-1:0]             o_active_src
);

    if (N_IN < 1 || N_IN > RR_MUX_MAX_IN || ID_BITS < SRC_BITS) begin : g_param_check
        $error("axis_rr_mux: N_IN must be 1..16 and ID_BITS must hold a source index");
    end

    // Returns {found, index} of the first requester at or after base, wrapping.
    function automatic logic [SRC_BITS:0] rr_pick(input logic [N_IN-1:0] req,
                                                  input logic [SRC_BITS-1:0] base);
        logic [SRC_BITS:0] res;
        int                idx;
        res = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = (int'(base) + k) % N_IN;
            if (req[idx]) begin
                res = {1'b1, SRC_BITS'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [SRC_BITS-1:0] wrap_inc(input logic [SRC_BITS-1:0] v);
        if (v == SRC_BITS'(N_IN - 1)) begin
            return '0;
        end
        return v + SRC_BITS'(1);
    endfunction

    rr_state_t             r_state;
    rr_state_t             w_state_nxt;
    logic [SRC_BITS-1:0]   r_ptr;
    logic [SRC_BITS-1:0]   w_ptr_nxt;
    logic [SRC_BITS-1:0]   r_g;
    logic [SRC_BITS-1:0]   w_g_nxt;
    logic [SRC_BITS-1:0]   w_base;
    logic [SRC_BITS:0]     w_pick;
    logic                  w_found;
    logic [SRC_BITS-1:0]   w_next;
    logic                  w_locked;
    logic                  w_last_hs;
    logic                  w_up_ready;
    logic [DATA_BITS-1:0]  w_mux_tdata;
    logic [KEEP_BITS-1:0]  w_mux_tkeep;
    logic                  w_mux_tlast;
    logic                  w_mux_tvalid;
    logic [ID_BITS-1:0]    w_mux_tid;

    assign w_locked  = (r_state == RR_LOCKED);
    assign w_last_hs = w_locked & w_mux_tvalid & w_mux_tlast & w_up_ready;
    // On a last beat the finished source drops to lowest priority.
    assign w_base    = w_last_hs ? wrap_inc(r_g) : r_ptr;
    assign w_pick    = rr_pick(i_s_tvalid, w_base);
    assign w_found   = w_pick[SRC_BITS];
    assign w_next    = w_pick[SRC_BITS-1:0];

    assign o_busy       = w_locked;
    assign o_active_src = r_g;

    // State, pointer and grant registers; reset drops any lock immediately.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state <= RR_IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_g     <= w_g_nxt;
        end
    end

    // Next grant: taken from IDLE on any request, re-evaluated only at a last-beat handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_g_nxt     = r_g;
        case (r_state)
            RR_IDLE: begin
                if (w_found) begin
                    w_state_nxt = RR_LOCKED;
                    w_g_nxt     = w_next;
                end
            end
            RR_LOCKED: begin
                if (w_last_hs) begin
                    w_ptr_nxt = wrap_inc(r_g);
                    if (w_found) begin
                        w_g_nxt = w_next;
                    end else begin
                        w_state_nxt = RR_IDLE;
                    end
                end
            end
            default: w_state_nxt = RR_IDLE;
        endcase
    end

    // Granted source drives the output stage; everything is zero while idle.
    always_comb begin
        w_mux_tdata  = '0;
        w_mux_tkeep  = '0;
        w_mux_tlast  = 1'b0;
        w_mux_tvalid = 1'b0;
        w_mux_tid    = '0;
        o_s_tready   = '0;
        if (w_locked) begin
            w_mux_tdata             = i_s_tdata[r_g];
            w_mux_tkeep             = i_s_tkeep[r_g];
            w_mux_tlast             = i_s_tlast[r_g];
            w_mux_tvalid            = i_s_tvalid[r_g];
            w_mux_tid[SRC_BITS-1:0] = r_g;
            o_s_tready[r_g]         = w_up_ready;
        end
    end

`ifdef AXIS_RR_MUX_OUT_REG_EN
    axis_skid_reg #(
        .DATA_BITS (DATA_BITS),
        .ID_BITS   (ID_BITS)
    ) u_out_reg (
        .i_clk      (i_aclk),
        .i_rst      (i_areset),
        .i_s_tdata  (w_mux_tdata),
        .i_s_tkeep  (w_mux_tkeep),
        .i_s_tlast  (w_mux_tlast),
        .i_s_tid    (w_mux_tid),
        .i_s_tvalid (w_mux_tvalid),
        .o_s_tready (w_up_ready),
        .o_m_tdata  (o_m_tdata),
        .o_m_tkeep  (o_m_tkeep),
        .o_m_tlast  (o_m_tlast),
        .o_m_tid    (o_m_tid),
        .o_m_tvalid (o_m_tvalid),
        .i_m_tready (i_m_tready)
    );
`else
    assign o_m_tdata  = w_mux_tdata;
    assign o_m_tkeep  = w_mux_tkeep;
    assign o_m_tlast  = w_mux_tlast;
    assign o_m_tid    = w_mux_tid;
    assign o_m_tvalid = w_mux_tvalid;
    assign w_up_ready = i_m_tready;
`endif

endmodule

// File: tb/tb_axis_rr_mux.sv
// Bench for axis_rr_mux (default build, N_IN=4, 32-bit data): per-source beat queues drive
// the inputs, expected beats go into a scoreboard that an output monitor drains.
module tb_axis_rr_mux;

    typedef struct packed {
        logic [3:0]  tid;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0][31:0]  s_tdata;
    logic [3:0][3:0]   s_tkeep;
    logic [3:0]        s_tlast;
    logic [3:0]        s_tvalid;
    logic [3:0]        s_tready;
    logic [31:0]       m_tdata;
    logic [3:0]        m_tkeep;
    logic              m_tlast;
    logic [3:0]        m_tid;
    logic              m_tvalid;
    logic              m_tready;
    logic              busy;
    logic [1:0]        active_src;

    beat_t src_q [4][$];
    beat_t exp_q [$];
    int    hs_times [$];
    logic [3:0] hold;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;

    axis_rr_mux #(.N_IN(4), .DATA_BITS(32), .ID_BITS(4)) dut (
        .i_aclk       (clk),
        .i_areset     (rst),
        .i_s_tdata    (s_tdata),
        .i_s_tkeep    (s_tkeep),
        .i_s_tlast    (s_tlast),
        .i_s_tvalid   (s_tvalid),
        .o_s_tready   (s_tready),
        .o_m_tdata    (m_tdata),
        .o_m_tkeep    (m_tkeep),
        .o_m_tlast    (m_tlast),
        .o_m_tid      (m_tid),
        .o_m_tvalid   (m_tvalid),
        .i_m_tready   (m_tready),
        .o_busy       (busy),
        .o_active_src (active_src)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic beat_t mk(int s, int b, int n, int tag);
        beat_t r;
        r.tid  = 4'(s);
        r.data = {8'(tag), 8'(s), 8'(b), 8'h5A};
        r.keep = (b == n - 1) ? 4'h7 : 4'hF;
        r.last = (b == n - 1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic add_pkt(int s, int n, int tag);
        for (int b = 0; b < n; b++) src_q[s].push_back(mk(s, b, n, tag));
    endtask

    task automatic exp_pkt(int s, int n, int tag);
        for (int b = 0; b < n; b++) exp_q.push_back(mk(s, b, n, tag));
    endtask

    task automatic apply();
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() != 0 && !hold[i]) begin
                b = src_q[i][0];
                s_tvalid[i] = 1'b1;
                s_tdata[i]  = b.data;
                s_tkeep[i]  = b.keep;
                s_tlast[i]  = b.last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i]  = '0;
                s_tkeep[i]  = '0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    // Handshakes are captured before the edge, sources advance just after it.
    task automatic step();
        logic [3:0] hs;
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        apply();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        hold = '0;
        m_tready = 1'b1;
        apply();
        @(posedge clk);
        #2;
        rst = 1'b0;
        hs_times.delete();
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_busy"},   64'(busy), 64'd0);
        chk({pfx, "_src"},    64'(active_src), 64'd0);
        chk({pfx, "_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({pfx, "_tlast"},  64'(m_tlast), 64'd0);
        chk({pfx, "_tid"},    64'(m_tid), 64'd0);
        chk({pfx, "_tdata"},  64'(m_tdata), 64'd0);
        chk({pfx, "_tkeep"},  64'(m_tkeep), 64'd0);
        chk({pfx, "_tready"}, 64'(s_tready), 64'd0);
    endtask

    // Output monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        beat_t got;
        if (!rst && m_tvalid && m_tready) begin
            hs_times.push_back(cyc);
            got = {m_tid, m_tdata, m_tkeep, m_tlast};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: actual=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL beat: actual=%h required=%h (t=%0t)", got, e, $time);
                end
            end
        end
    end

    initial begin
        int bidx;
        int pat [6] = '{1, 0, 0, 1, 1, 1};

        // Reset values
        rst = 1'b1;
        hold = '0;
        m_tready = 1'b1;
        apply();
        #2;
        chk_quiet("reset");

        // Single source 2, 3 beats
        do_reset();
        add_pkt(2, 3, 1);
        exp_pkt(2, 3, 1);
        apply();
        #1;
        chk("single_first_cycle_tvalid", 64'(m_tvalid), 64'd0);
        chk("single_first_cycle_busy", 64'(busy), 64'd0);
        step();
        chk("single_tvalid", 64'(m_tvalid), 64'd1);
        chk("single_tid", 64'(m_tid), 64'd2);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_active_src", 64'(active_src), 64'd2);
        chk("single_tready", 64'(s_tready), 64'b0100);
        step();
        step();
        step();
        chk("single_beats", 64'(hs_times.size()), 64'd3);
        if (hs_times.size() == 3)
            chk("single_consecutive", 64'(hs_times[2] - hs_times[0]), 64'd2);
        chk("single_after_tvalid", 64'(m_tvalid), 64'd0);
        chk("single_other_tready", 64'(s_tready & 4'b1011), 64'd0);
        chk("single_sb_empty", 64'(exp_q.size()), 64'd0);

        // All four sources, 2-beat packets, source 0 has a second packet
        do_reset();
        add_pkt(0, 2, 10);
        add_pkt(0, 2, 14);
        add_pkt(1, 2, 11);
        add_pkt(2, 2, 12);
        add_pkt(3, 2, 13);
        exp_pkt(0, 2, 10);
        exp_pkt(1, 2, 11);
        exp_pkt(2, 2, 12);
        exp_pkt(3, 2, 13);
        exp_pkt(0, 2, 14);
        apply();
        #1;
        for (int k = 0; k < 11; k++) step();
        chk("rr_beats", 64'(hs_times.size()), 64'd10);
        if (hs_times.size() == 10)
            chk("rr_no_bubble", 64'(hs_times[9] - hs_times[0]), 64'd9);
        chk("rr_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure on a packet from source 3
        do_reset();
        add_pkt(3, 4, 20);
        exp_pkt(3, 4, 20);
        apply();
        #1;
        step();
        bidx = 0;
        for (int k = 0; k < 6; k++) begin
            m_tready = pat[k][0];
            #1;
            chk("bp_tready", 64'(s_tready), pat[k] != 0 ? 64'b1000 : 64'd0);
            chk("bp_tdata", 64'(m_tdata), 64'(mk(3, bidx, 4, 20).data));
            chk("bp_tvalid", 64'(m_tvalid), 64'd1);
            if (pat[k] != 0) bidx++;
            step();
        end
        m_tready = 1'b1;
        chk("bp_beats", 64'(hs_times.size()), 64'd4);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Lock hold while source 0 pauses mid-packet
        do_reset();
        add_pkt(0, 4, 30);
        add_pkt(1, 2, 31);
        exp_pkt(0, 4, 30);
        exp_pkt(1, 2, 31);
        apply();
        #1;
        step();
        chk("hold_grant", 64'(active_src), 64'd0);
        step();
        step();
        hold[0] = 1'b1;
        apply();
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_tready", 64'(s_tready), 64'b0001);
            chk("hold_tvalid", 64'(m_tvalid), 64'd0);
            step();
        end
        hold[0] = 1'b0;
        apply();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("hold_src1_blocked", 64'(s_tready[1]), 64'd0);
            step();
        end
        chk("hold_src1_granted", 64'(active_src), 64'd1);
        step();
        step();
        step();
        chk("hold_beats", 64'(hs_times.size()), 64'd6);
        if (hs_times.size() == 6)
            chk("hold_no_bubble", 64'(hs_times[4] - hs_times[3]), 64'd1);
        chk("hold_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a packet from source 1
        do_reset();
        add_pkt(1, 1, 40);
        add_pkt(1, 4, 41);
        exp_pkt(1, 1, 40);
        exp_q.push_back(mk(1, 0, 4, 41));
        exp_q.push_back(mk(1, 1, 4, 41));
        apply();
        #1;
        step();
        step();
        step();
        step();
        chk("midrst_beat2_tvalid", 64'(m_tvalid), 64'd1);
        chk("midrst_beat2_tdata", 64'(m_tdata), 64'(mk(1, 2, 4, 41).data));
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        chk("midrst_sb_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 4; i++) src_q[i].delete();
        apply();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        hs_times.delete();
        add_pkt(0, 1, 42);
        add_pkt(3, 1, 43);
        exp_pkt(0, 1, 42);
        exp_pkt(3, 1, 43);
        apply();
        #1;
        step();
        chk("midrst_ptr_grant", 64'(active_src), 64'd0);
        chk("midrst_ptr_tid", 64'(m_tid), 64'd0);
        step();
        step();
        step();
        chk("midrst_after_beats", 64'(hs_times.size()), 64'd2);
        chk("midrst_after_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
